bound_accumulator: RTL and testbench

Sequential reduction stage placed directly downstream of the two-input signed minimum comparators. It takes a serial stream of activated/deactivated signed candidate bounds for one variable and produces the tightest lower bound (maximum of lower candidates) and the tightest upper bound (minimum of upper candidates). It also reports whether the resulting interval is feasible. The result is handed to the sampler through a valid/ready handshake.

---
 rtl/bound_accumulator.sv | 133 +++++++++++++
 tb/tb_bound_accumulator.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bound_accumulator.sv
// Serial reduction of signed candidate bounds into the tightest [lower, upper] interval,
// with a feasibility flag and a valid/ready result handshake.
`timescale 1ns/1ps
module bound_accumulator #(
  parameter int WIDTH     = 8,
  parameter int MAX_TERMS = 16,
  localparam int CW       = $clog2(MAX_TERMS + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_bound,
  input  logic                    in_bound_activation,
  input  logic                    in_is_upper,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_lower,
  output logic signed [WIDTH-1:0] out_upper,
  output logic                    out_lower_activation,
  output logic                    out_upper_activation,
  output logic                    out_feasible,
  output logic [CW-1:0]           out_count,
  output logic                    out_overflow
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DONE
  } state_e;

  localparam logic signed [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [CW-1:0]           MAX_CNT = CW'(MAX_TERMS);

  state_e                  state_q, state_d;
  logic signed [WIDTH-1:0] lower_q, lower_d;
  logic signed [WIDTH-1:0] upper_q, upper_d;
  logic                    lower_act_q, lower_act_d;
  logic                    upper_act_q, upper_act_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    overflow_q, overflow_d;
  logic                    accept;

  assign accept = in_valid && (state_q == S_ACCUM);

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path can infer a latch.
    state_d     = state_q;
    lower_d     = lower_q;
    upper_d     = upper_q;
    lower_act_d = lower_act_q;
    upper_act_d = upper_act_q;
    count_d     = count_q;
    overflow_d  = overflow_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_ACCUM;
          lower_d     = MIN_VAL;
          upper_d     = MAX_VAL;
          lower_act_d = 1'b0;
          upper_act_d = 1'b0;
          count_d     = '0;
          overflow_d  = 1'b0;
        end
      end

      S_ACCUM: begin
        if (accept) begin
          if (count_q == MAX_CNT) overflow_d = 1'b1;
          else                    count_d    = count_q + 1'b1;

          // The first active candidate of a side always replaces the sentinel; ties keep the stored value.
          if (in_bound_activation) begin
            if (in_is_upper) begin
              if (!upper_act_q || (in_bound < upper_q)) upper_d = in_bound;
              upper_act_d = 1'b1;
            end else begin
              if (!lower_act_q || (in_bound > lower_q)) lower_d = in_bound;
              lower_act_d = 1'b1;
            end
          end

          if (in_last) state_d = S_DONE;
        end
      end

      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: all state, including the result registers, is reset so a partial result can never leak out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      lower_q     <= MIN_VAL;
      upper_q     <= MAX_VAL;
      lower_act_q <= 1'b0;
      upper_act_q <= 1'b0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state_q     <= state_d;
      lower_q     <= lower_d;
      upper_q     <= upper_d;
      lower_act_q <= lower_act_d;
      upper_act_q <= upper_act_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
    end
  end

  assign in_ready             = (state_q == S_ACCUM);
  assign out_valid            = (state_q == S_DONE);
  assign out_lower            = lower_q;
  assign out_upper            = upper_q;
  assign out_lower_activation = lower_act_q;
  assign out_upper_activation = upper_act_q;
  assign out_count            = count_q;
  assign out_overflow         = overflow_q;
  assign out_feasible         = (lower_q <= upper_q);

endmodule

// File: tb/tb_bound_accumulator.sv
// Self-checking bench for bound_accumulator: directed scenarios plus randomized reductions
// compared every cycle against a max/min reference model of each reduction.
`timescale 1ns/1ps
module tb_bound_accumulator;

  localparam int WIDTH     = 8;
  localparam int MAX_TERMS = 16;
  localparam int CW        = $clog2(MAX_TERMS + 1);

  typedef enum int {P_IDLE, P_ACCUM, P_DONE} phase_e;

  typedef struct {
    logic signed [WIDTH-1:0] b;
    bit                      act;
    bit                      up;
  } cand_t;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    start;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] in_bound;
  logic                    in_bound_activation;
  logic                    in_is_upper;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] out_lower;
  logic signed [WIDTH-1:0] out_upper;
  logic                    out_lower_activation;
  logic                    out_upper_activation;
  logic                    out_feasible;
  logic [CW-1:0]           out_count;
  logic                    out_overflow;

  bound_accumulator #(.WIDTH(WIDTH), .MAX_TERMS(MAX_TERMS)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .start               (start),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .in_bound            (in_bound),
    .in_bound_activation (in_bound_activation),
    .in_is_upper         (in_is_upper),
    .in_last             (in_last),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .out_lower           (out_lower),
    .out_upper           (out_upper),
    .out_lower_activation(out_lower_activation),
    .out_upper_activation(out_upper_activation),
    .out_feasible        (out_feasible),
    .out_count           (out_count),
    .out_overflow        (out_overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected behaviour, maintained by the driver.
  phase_e                  phase      = P_IDLE;
  bit                      reset_vals = 1'b1;
  bit                      run        = 1'b0;
  cand_t                   model_q[$];
  logic signed [WIDTH-1:0] exp_lower;
  logic signed [WIDTH-1:0] exp_upper;
  bit                      exp_lo_act, exp_up_act, exp_feas, exp_ovf;
  int                      exp_count;

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_reset_expect();
    exp_lower  = -128;
    exp_upper  = 127;
    exp_lo_act = 0;
    exp_up_act = 0;
    exp_count  = 0;
    exp_ovf    = 0;
    exp_feas   = 1;
  endtask

  // Tightest bounds from their definition: max of active lowers, min of active uppers.
  task automatic compute_expect();
    int n = 0;
    set_reset_expect();
    foreach (model_q[i]) begin
      n++;
      if (model_q[i].act) begin
        if (model_q[i].up) begin
          if (!exp_up_act || model_q[i].b < exp_upper) exp_upper = model_q[i].b;
          exp_up_act = 1;
        end else begin
          if (!exp_lo_act || model_q[i].b > exp_lower) exp_lower = model_q[i].b;
          exp_lo_act = 1;
        end
      end
    end
    exp_count = (n > MAX_TERMS) ? MAX_TERMS : n;
    exp_ovf   = (n > MAX_TERMS);
    exp_feas  = (exp_lower <= exp_upper);
  endtask

  always @(negedge clk) begin
    if (run) begin
      check("in_ready", in_ready, (phase == P_ACCUM));
      check("out_valid", out_valid, (phase == P_DONE));
      if (phase == P_DONE || reset_vals) begin
        check("out_lower", out_lower, exp_lower);
        check("out_upper", out_upper, exp_upper);
        check("out_lower_act", out_lower_activation, exp_lo_act);
        check("out_upper_act", out_upper_activation, exp_up_act);
        check("out_count", out_count, exp_count);
        check("out_overflow", out_overflow, exp_ovf);
        check("out_feasible", out_feasible, exp_feas);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_red();
    start = 1;
    tick();
    start = 0;
    model_q.delete();
    phase = P_ACCUM;
    reset_vals = 0;
  endtask

  task automatic send(input logic signed [WIDTH-1:0] b, input bit act, input bit up, input bit last);
    cand_t c;
    in_valid = 1; in_bound = b; in_bound_activation = act; in_is_upper = up; in_last = last;
    tick();
    in_valid = 0; in_bound = WIDTH'($urandom); in_last = $urandom_range(0, 1);
    c.b = b; c.act = act; c.up = up;
    model_q.push_back(c);
    if (last) begin
      compute_expect();
      phase = P_DONE;
    end
  endtask

  task automatic finish_red(input int hold, input bit poke);
    repeat (hold) begin
      start = poke;
      in_valid = poke;
      tick();
    end
    start = 0; in_valid = 0;
    out_ready = 1;
    tick();
    out_ready = 0;
    phase = P_IDLE;
  endtask

  task automatic check_result(input string tag, input int lo, input int up, input int la, input int ua,
                              input int feas, input int cnt, input int ovf);
    check({tag, "_lower"}, out_lower, lo);
    check({tag, "_upper"}, out_upper, up);
    check({tag, "_lo_act"}, out_lower_activation, la);
    check({tag, "_up_act"}, out_upper_activation, ua);
    check({tag, "_feasible"}, out_feasible, feas);
    check({tag, "_count"}, out_count, cnt);
    check({tag, "_overflow"}, out_overflow, ovf);
  endtask

  initial begin
    rst_n = 0; start = 0; in_valid = 0; in_bound = '0; in_bound_activation = 0;
    in_is_upper = 0; in_last = 0; out_ready = 0;
    set_reset_expect();
    tick(); tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check_result("rst", -128, 127, 0, 0, 1, 0, 0);
    rst_n = 1;
    run = 1;
    tick();

    // Mixed bounds ending infeasible.
    begin_red();
    send(10, 1, 1, 0); send(-3, 1, 1, 0); send(7, 1, 1, 0); send(-20, 1, 0, 0); send(5, 1, 0, 1);
    check_result("s1", 5, -3, 1, 1, 0, 5, 0);
    finish_red(0, 0);

    // Inactive candidate must be ignored.
    begin_red();
    send(50, 0, 1, 0); send(20, 1, 1, 0); send(-8, 1, 0, 1);
    check_result("s2", -8, 20, 1, 1, 1, 3, 0);
    finish_red(0, 0);

    // Only inactive candidates leave the sentinels in place.
    begin_red();
    send(-5, 0, 0, 0); send(9, 0, 1, 0); send(0, 0, 0, 1);
    check_result("s3", -128, 127, 0, 0, 1, 3, 0);
    finish_red(0, 0);

    // Seventeen lower candidates: count saturates, overflow sticks, max still tracked.
    begin_red();
    for (int i = 0; i < 17; i++) send(WIDTH'(((i * 37) % 100) - 50), 1, 0, i == 16);
    check_result("s4", 46, 127, 1, 0, 1, 16, 1);
    // Backpressure with start and in_valid poked during DONE.
    finish_red(5, 1);
    check("s5_idle_valid", out_valid, 0);
    check("s5_idle_ready", in_ready, 0);

    // Reset mid-reduction clears everything at once.
    begin_red();
    send(3, 1, 1, 0); send(-2, 1, 0, 0);
    in_valid = 1; in_bound = 1; in_bound_activation = 1; in_is_upper = 1; in_last = 0;
    rst_n = 0;
    #1;
    phase = P_IDLE; reset_vals = 1; set_reset_expect();
    check("s6_valid", out_valid, 0);
    check("s6_ready", in_ready, 0);
    check_result("s6", -128, 127, 0, 0, 1, 0, 0);
    in_valid = 0;
    tick(); tick();
    rst_n = 1;
    tick();
    begin_red();
    send(-60, 1, 1, 0); send(-70, 1, 0, 1);
    check_result("s6b", -70, -60, 1, 1, 1, 2, 0);
    finish_red(1, 0);

    // Randomized reductions with gaps, ignored starts and varying consumer delay.
    for (int r = 0; r < 40; r++) begin
      int len;
      len = $urandom_range(1, (r % 5 == 0) ? 20 : 8);
      begin_red();
      for (int k = 0; k < len; k++) begin
        int gaps;
        gaps = $urandom_range(0, 2);
        repeat (gaps) begin
          start = ($urandom_range(0, 3) == 0);
          tick();
        end
        start = 0;
        send(WIDTH'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 1), k == len - 1);
      end
      finish_red($urandom_range(0, 3), $urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) tick();
    end

    run = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
